mem_arbiter: RTL and testbench

Round-robin arbiter that shares the single main-memory port between `num_procs` coprocessor instances, each of which raises a request and drives the memory bus only while granted. The arbiter issues a one-hot registered grant, holds it for as long as the owner keeps requesting, and inserts one dead (turnaround) cycle between owners so tri-stated bus drivers never overlap. It sits between the processor array and the memory and is sequenced only by the processors' request lines.

---
 rtl/mem_arbiter_pkg.sv | 5 +
 rtl/mem_arbiter_if.sv | 12 +
 rtl/mem_arbiter_pick.sv | 28 ++
 rtl/mem_arbiter.sv | 77 +++++++
 tb/tb_mem_arbiter.sv | 127 ++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared state encoding and size limit for the memory-port arbiter
package mem_arb_pkg;
  localparam int MAX_PROCS = 16;
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_TURN} arb_state_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request/grant bundle between the processor array and the arbiter
interface mem_arbiter_if #(
  parameter int num_procs = 4,
  parameter int owner_width = $clog2(num_procs)
) ();
  logic [num_procs-1:0] in_request;
  logic [num_procs-1:0] out_grant;
  logic [owner_width-1:0] out_owner;
  logic out_busy;
  modport master (output in_request, input out_grant, out_owner, out_busy);
  modport slave (input in_request, output out_grant, out_owner, out_busy);
endinterface

// File: rtl/mem_arbiter_pick.sv
// rr_priority_pick: first set request bit scanning upward from start_i with wrap-around
module rr_priority_pick #(
  parameter int num_procs = 4,
  parameter int owner_width = $clog2(num_procs)
) (
  input  logic [num_procs-1:0]   req_i,
  input  logic [owner_width-1:0] start_i,
  output logic [num_procs-1:0]   grant_o,
  output logic [owner_width-1:0] idx_o,
  output logic                   found_o
);
  int j;
  always_comb begin
    grant_o = '0;
    idx_o = '0;
    found_o = 1'b0;
    j = 0;
    for (int i = 0; i < num_procs; i++) begin
      j = int'(start_i) + i;
      j = (j >= num_procs) ? j - num_procs : j;
      if (!found_o && req_i[j]) begin
        found_o = 1'b1;
        idx_o = owner_width'(j);
        grant_o[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin memory-port arbiter with one dead cycle between owners.
// Define MEM_ARB_TIMEOUT_EN to revoke a grant held max_hold cycles while others wait.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int num_procs = 4,
  parameter int owner_width = $clog2(num_procs),
  parameter int max_hold = 64,
  parameter int hold_width = $clog2(max_hold + 1)
) (
  input  logic          in_clk,
  input  logic          in_reset,
  mem_arbiter_if.slave  bus
);
  if (num_procs < 2 || num_procs > MAX_PROCS) begin : g_bad_size
    $error("mem_arbiter: num_procs out of range");
  end
  localparam logic [owner_width-1:0] LAST = owner_width'(num_procs - 1);
  arb_state_e state_q;
  logic [num_procs-1:0] grant_q, pick_grant;
  logic [owner_width-1:0] owner_q, last_q, start, pick_idx;
  logic busy_q, pick_found, revoke;
  assign start = (last_q == LAST) ? '0 : last_q + 1'b1;
  rr_priority_pick #(.num_procs(num_procs), .owner_width(owner_width)) u_pick (
    .req_i(bus.in_request),
    .start_i(start),
    .grant_o(pick_grant),
    .idx_o(pick_idx),
    .found_o(pick_found)
  );
`ifdef MEM_ARB_TIMEOUT_EN
  logic [hold_width-1:0] hold_q;
  assign revoke = (hold_q == hold_width'(max_hold)) && |(bus.in_request & ~grant_q);
`else
  assign revoke = 1'b0;
`endif
  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      busy_q <= 1'b0;
      last_q <= LAST;
`ifdef MEM_ARB_TIMEOUT_EN
      hold_q <= '0;
`endif
    end else begin
      case (state_q)
        S_GRANT: begin
          if (!bus.in_request[owner_q] || revoke) begin
            grant_q <= '0;
            busy_q <= 1'b0;
            state_q <= S_TURN;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else hold_q <= (hold_q == hold_width'(max_hold)) ? hold_q : hold_q + 1'b1;
`endif
        end
        default: begin
          state_q <= pick_found ? S_GRANT : S_IDLE;
          if (pick_found) begin
            grant_q <= pick_grant;
            owner_q <= pick_idx;
            last_q <= pick_idx;
            busy_q <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
            hold_q <= '0;
`endif
          end
        end
      endcase
    end
  end
  assign bus.out_grant = grant_q;
  assign bus.out_owner = owner_q;
  assign bus.out_busy = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of grant order, turnaround, hold, wrap and async reset
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  mem_arbiter_if #(.num_procs(4)) bus ();
  mem_arbiter #(.num_procs(4), .max_hold(8)) dut (
    .in_clk(clk),
    .in_reset(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] o);
    chk({tag, ".grant"}, 32'(bus.out_grant), 32'(g));
    chk({tag, ".busy"}, 32'(bus.out_busy), 32'(g != 4'b0));
    if (g != 4'b0) chk({tag, ".owner"}, 32'(bus.out_owner), 32'(o));
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_request = 4'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask
  initial begin
    logic [1:0] ord [5];
    ord = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    chk("reset.grant", 32'(bus.out_grant), 32'h0);
    chk("reset.busy", 32'(bus.out_busy), 32'h0);
    chk("reset.owner", 32'(bus.out_owner), 32'h0);
    bus.in_request = 4'b0001;
    step();
    chk_out("single.grant", 4'b0001, 2'd0);
    bus.in_request = 4'b0000;
    step();
    chk_out("single.release", 4'b0000, 2'd0);
    step();
    chk_out("single.idle", 4'b0000, 2'd0);
    do_reset();
    bus.in_request = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      chk_out($sformatf("rr.own%0d.c0", k), 4'b1 << ord[k], ord[k]);
      if (k == 4) break;
      step();
      chk_out($sformatf("rr.own%0d.c1", k), 4'b1 << ord[k], ord[k]);
      step();
      chk_out($sformatf("rr.own%0d.c2", k), 4'b1 << ord[k], ord[k]);
      bus.in_request[ord[k]] = 1'b0;
      step();
      chk_out($sformatf("rr.dead%0d", k), 4'b0000, 2'd0);
      bus.in_request[ord[k]] = 1'b1;
      step();
    end
    do_reset();
    bus.in_request = 4'b1000;
    step();
    chk_out("wrap.own3", 4'b1000, 2'd3);
    bus.in_request = 4'b1110;
    step();
    chk_out("wrap.hold3", 4'b1000, 2'd3);
    bus.in_request = 4'b0110;
    step();
    chk_out("wrap.dead", 4'b0000, 2'd0);
    step();
    chk_out("wrap.own1", 4'b0010, 2'd1);
`ifndef MEM_ARB_TIMEOUT_EN
    do_reset();
    bus.in_request = 4'b0100;
    step();
    chk_out("hold.grant", 4'b0100, 2'd2);
    bus.in_request = 4'b0111;
    for (int k = 0; k < 20; k++) begin
      step();
      chk_out($sformatf("hold.c%0d", k), 4'b0100, 2'd2);
    end
`else
    do_reset();
    bus.in_request = 4'b0011;
    for (int k = 0; k < 9; k++) begin
      step();
      chk_out($sformatf("tmo.own0.c%0d", k), 4'b0001, 2'd0);
    end
    step();
    chk_out("tmo.dead", 4'b0000, 2'd0);
    step();
    chk_out("tmo.own1", 4'b0010, 2'd1);
    do_reset();
    bus.in_request = 4'b0001;
    for (int k = 0; k < 14; k++) begin
      step();
      chk_out($sformatf("tmo.keep.c%0d", k), 4'b0001, 2'd0);
    end
`endif
    do_reset();
    bus.in_request = 4'b0010;
    step();
    chk_out("midrst.grant", 4'b0010, 2'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.grant0", 32'(bus.out_grant), 32'h0);
    chk("midrst.busy0", 32'(bus.out_busy), 32'h0);
    chk("midrst.owner0", 32'(bus.out_owner), 32'h0);
    bus.in_request = 4'b1010;
    step();
    chk_out("midrst.held", 4'b0000, 2'd0);
    rst_n = 1'b1;
    step();
    chk_out("midrst.own1", 4'b0010, 2'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
